// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO library: default geometry and the word packer's
// two-state output encoding.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_PACK_RATIO = 4;

  // FILL: output register empty; HOLD: output register holds a word (out_valid=1).
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } pack_state_e;

endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO read port plus packed output stream of the word packer, bundled as one interface.
interface fifo_word_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK_RATIO = 4
);

  logic                             fifo_rd_en;
  logic [DATA_WIDTH-1:0]            fifo_rd_data;
  logic                             fifo_empty;
  logic                             flush;
  logic                             out_valid;
  logic [DATA_WIDTH*PACK_RATIO-1:0] out_data;
  logic [PACK_RATIO-1:0]            out_keep;
  logic                             out_last;
  logic                             out_ready;
  logic                             busy;

  // master is the packer itself; slave is the FIFO/downstream environment.
  modport master (
    output fifo_rd_en, out_valid, out_data, out_keep, out_last, busy,
    input  fifo_rd_data, fifo_empty, flush, out_ready
  );

  modport slave (
    input  fifo_rd_en, out_valid, out_data, out_keep, out_last, busy,
    output fifo_rd_data, fifo_empty, flush, out_ready
  );

endinterface

// File: rtl/fifo_word_packer.sv
// Drains a show-ahead FIFO, packing PACK_RATIO narrow words into one wide word on a
// valid/ready stream; a flush closes a partial word early with a keep mask and last flag.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  PACK_RATIO = DEFAULT_PACK_RATIO,
  localparam int IDX_WIDTH  = $clog2(PACK_RATIO)
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_word_packer_if.master bus
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(PACK_RATIO - 1);

  pack_state_e                          state_q, state_d;
  logic [IDX_WIDTH-1:0]                 idx_q, idx_d;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] acc_q, acc_d;
  logic [PACK_RATIO-1:0]                acc_keep_q, acc_keep_d;
  logic                                 flush_pending_q, flush_pending_d;
  logic                                 out_valid_q, out_valid_d;
  logic [DATA_WIDTH*PACK_RATIO-1:0]     out_data_q, out_data_d;
  logic [PACK_RATIO-1:0]                out_keep_q, out_keep_d;
  logic                                 out_last_q, out_last_d;

  logic                                 out_free;
  logic                                 pop;
  logic                                 closes;
  logic                                 eff_flush;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] acc_merged;
  logic [PACK_RATIO-1:0]                keep_merged;

  // The output register can take a new word this cycle if it is empty or being drained.
  assign out_free  = (state_q == ST_FILL) || bus.out_ready;
  assign pop       = rst_n && !bus.fifo_empty && out_free;
  assign closes    = pop && (idx_q == LAST_IDX);
  assign eff_flush = bus.flush || flush_pending_q;

  // Accumulator as it would look after this cycle's pop, before any emit decision.
  for (genvar gi = 0; gi < PACK_RATIO; gi++) begin : g_lane
    logic lane_hit;
    assign lane_hit        = pop && (idx_q == IDX_WIDTH'(gi));
    assign acc_merged[gi]  = lane_hit ? bus.fifo_rd_data : acc_q[gi];
    assign keep_merged[gi] = acc_keep_q[gi] | lane_hit;
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    acc_d           = acc_q;
    acc_keep_d      = acc_keep_q;
    flush_pending_d = flush_pending_q;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    out_keep_d      = out_keep_q;
    out_last_d      = out_last_q;

    if (state_q == ST_HOLD && bus.out_ready) begin
      state_d     = ST_FILL;
      out_valid_d = 1'b0;
    end

    if (closes) begin
      // A pop implies out_free, so any effective flush is consumed by the full word.
      state_d         = ST_HOLD;
      out_valid_d     = 1'b1;
      out_data_d      = acc_merged;
      out_keep_d      = '1;
      out_last_d      = eff_flush;
      acc_d           = '0;
      acc_keep_d      = '0;
      idx_d           = '0;
      flush_pending_d = 1'b0;
    end else if (out_free && eff_flush) begin
      flush_pending_d = 1'b0;
      if (keep_merged != '0) begin
        // Unused lanes are already zero because acc is cleared on every emit.
        state_d     = ST_HOLD;
        out_valid_d = 1'b1;
        out_data_d  = acc_merged;
        out_keep_d  = keep_merged;
        out_last_d  = 1'b1;
        acc_d       = '0;
        acc_keep_d  = '0;
        idx_d       = '0;
      end
    end else begin
      acc_d      = acc_merged;
      acc_keep_d = keep_merged;
      if (pop) begin
        idx_d = idx_q + IDX_WIDTH'(1);
      end
      if (!out_free && bus.flush) begin
        flush_pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_FILL;
      idx_q           <= '0;
      acc_q           <= '0;
      acc_keep_q      <= '0;
      flush_pending_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_keep_q      <= '0;
      out_last_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      acc_q           <= acc_d;
      acc_keep_q      <= acc_keep_d;
      flush_pending_q <= flush_pending_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_keep_q      <= out_keep_d;
      out_last_q      <= out_last_d;
    end
  end

  assign bus.fifo_rd_en = pop;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_keep   = out_keep_q;
  assign bus.out_last   = out_last_q;
  assign bus.busy       = (acc_keep_q != '0) || out_valid_q || flush_pending_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: directed scenarios plus randomized traffic,
// checked against a transaction-level model built from popped words and flush events.
module tb_fifo_word_packer;

  localparam int DW = 8;
  localparam int PR = 4;

  typedef struct packed {
    logic [DW*PR-1:0] d;
    logic [PR-1:0]    k;
    logic             l;
  } word_t;

  logic clk;
  logic rst_n;

  fifo_word_packer_if #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) bus ();

  fifo_word_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;
  int pops_seen = 0;

  logic [DW-1:0] fq[$];    // the FIFO the bench plays
  logic [DW-1:0] pend[$];  // words popped but not yet emitted
  bit            req;      // flush waiting for the output register
  word_t         exp_q[$]; // words loaded into the output register, not yet accepted

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void emit(input bit last);
    word_t w;
    w.d = '0;
    for (int i = 0; i < pend.size(); i++) w.d[DW*i +: DW] = pend[i];
    w.k = PR'((1 << pend.size()) - 1);
    w.l = last;
    exp_q.push_back(w);
    pend.delete();
  endfunction

  task automatic drive_fifo();
    bus.fifo_empty   = (fq.size() == 0);
    bus.fifo_rd_data = (fq.size() != 0) ? fq[0] : '0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle(input bit fl, input bit rdy);
    bit    model_valid, free, exp_rd, was_rd;
    word_t w;
    bus.flush     = fl;
    bus.out_ready = rdy;
    drive_fifo();
    #1;
    model_valid = (exp_q.size() != 0);
    free        = !model_valid || rdy;
    exp_rd      = (fq.size() != 0) && free;
    was_rd      = bus.fifo_rd_en;
    check_eq("rd_en", 64'(bus.fifo_rd_en), 64'(exp_rd));
    check_eq("busy", 64'(bus.busy), 64'((pend.size() != 0) || model_valid || req));
    check_eq("out_valid", 64'(bus.out_valid), 64'(model_valid));
    if (model_valid) begin
      w = exp_q[0];
      check_eq("out_data", 64'(bus.out_data), 64'(w.d));
      check_eq("out_keep", 64'(bus.out_keep), 64'(w.k));
      check_eq("out_last", 64'(bus.out_last), 64'(w.l));
      if (rdy) begin
        n_txn++;
        $display("txn %0d: data=%h keep=%b last=%b", n_txn, bus.out_data, bus.out_keep, bus.out_last);
        void'(exp_q.pop_front());
      end
    end
    if (exp_rd) pend.push_back(fq[0]);
    if (free && (fl || req)) begin
      if (pend.size() != 0) emit(1'b1);
      req = 1'b0;
    end else if (pend.size() == PR) begin
      emit(1'b0);
    end else if (fl && !free) begin
      req = 1'b1;
    end
    @(posedge clk);
    if (was_rd) begin
      pops_seen++;
      if (fq.size() != 0) void'(fq.pop_front());
    end
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive_fifo();
    #1;
    check_eq("rd_en_in_reset", 64'(bus.fifo_rd_en), 64'd0);
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pend.delete();
    exp_q.delete();
    req = 1'b0;
    check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_data", 64'(bus.out_data), 64'd0);
    check_eq("rst_keep", 64'(bus.out_keep), 64'd0);
    check_eq("rst_last", 64'(bus.out_last), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, drain;
    bit fl, rdy;
    int push_p, flush_p, rdy_p;
    rst_n            = 1'b0;
    req              = 1'b0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b0;
    bus.fifo_empty   = 1'b1;
    bus.fifo_rd_data = '0;
    do_reset(2);

    // Single full word.
    fq = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (4) cycle(1'b0, 1'b1);
    check_eq("full_valid", 64'(bus.out_valid), 64'd1);
    check_eq("full_data", 64'(bus.out_data), 64'h44332211);
    check_eq("full_keep", 64'(bus.out_keep), 64'hf);
    cycle(1'b0, 1'b1);
    check_eq("full_busy_after", 64'(bus.busy), 64'd0);

    // Eight words streamed without a bubble.
    fq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    p0 = pops_seen;
    repeat (8) cycle(1'b0, 1'b1);
    check_eq("stream_pops", 64'(pops_seen - p0), 64'd8);
    check_eq("stream_data2", 64'(bus.out_data), 64'h08070605);
    cycle(1'b0, 1'b1);

    // Partial word closed by a flush, then a flush with nothing held.
    fq = '{8'hAA, 8'hBB};
    repeat (2) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    check_eq("partial_data", 64'(bus.out_data), 64'h0000BBAA);
    check_eq("partial_keep", 64'(bus.out_keep), 64'h3);
    check_eq("partial_last", 64'(bus.out_last), 64'd1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    check_eq("empty_flush_valid", 64'(bus.out_valid), 64'd0);

    // Stalled output with a non-empty FIFO, then accept with a concurrent pop.
    fq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    repeat (4) cycle(1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0);
    check_eq("stall_fifo_kept", 64'(fq.size()), 64'd1);
    cycle(1'b0, 1'b1);
    check_eq("stall_lane0_pop", 64'(fq.size()), 64'd0);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);

    // Flush arriving during a stalled HOLD becomes pending.
    fq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    repeat (4) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check_eq("pend_data", 64'(bus.out_data), 64'h00000035);
    check_eq("pend_keep", 64'(bus.out_keep), 64'h1);
    check_eq("pend_last", 64'(bus.out_last), 64'd1);
    cycle(1'b0, 1'b1);

    // Reset mid-word, then a clean word.
    fq = '{8'h51, 8'h52, 8'h53};
    repeat (3) cycle(1'b0, 1'b1);
    do_reset(1);
    fq = '{8'h41, 8'h42, 8'h43, 8'h44};
    repeat (4) cycle(1'b0, 1'b1);
    check_eq("post_rst_data", 64'(bus.out_data), 64'h44434241);
    check_eq("post_rst_last", 64'(bus.out_last), 64'd0);
    cycle(1'b0, 1'b1);

    // Randomized traffic in segments of differing density, with one reset.
    for (int seg = 0; seg < 4; seg++) begin
      push_p  = 30 + 20 * seg;
      flush_p = (seg == 3) ? 25 : 8;
      rdy_p   = (seg == 1) ? 40 : 80;
      if (seg == 2) do_reset(1);
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(99) < push_p && fq.size() < 16) fq.push_back(DW'($urandom));
        fl  = ($urandom_range(99) < flush_p);
        rdy = ($urandom_range(99) < rdy_p);
        cycle(fl, rdy);
      end
    end

    drain = 0;
    while ((exp_q.size() != 0 || fq.size() != 0 || pend.size() != 0 || req) && drain < 60) begin
      cycle(drain % 3 == 2, 1'b1);
      drain++;
    end
    check_eq("drain_done", 64'(exp_q.size() + fq.size() + pend.size()), 64'd0);
    check_eq("drain_valid", 64'(bus.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
